core_ni_inject: RTL and testbench

CORE_NI_INJECT -- requirements
Module: core_ni_inject

---
 rtl/core_ni_inject_if.sv | 25 ++
 rtl/core_ni_inject.sv | 130 +++++++++++++
 tb/tb_core_ni_inject.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_ni_inject_if.sv
// Core-side bundle of the NI injection port: command and payload channels in,
// flit stream toward the router core out.
interface core_ni_inject_if;
    logic        cmd_valid;
    logic [7:0]  cmd_dest;
    logic [3:0]  cmd_len;
    logic        cmd_ready;
    logic        pl_valid;
    logic [31:0] pl_data;
    logic        pl_ready;
    logic [31:0] core_packet;
    logic        core_in_val;
    logic        data_in_req_from_core;
    logic        pkt_sent;

    modport master (
        output cmd_valid, cmd_dest, cmd_len, pl_valid, pl_data, data_in_req_from_core,
        input  cmd_ready, pl_ready, core_packet, core_in_val, pkt_sent
    );

    modport slave (
        input  cmd_valid, cmd_dest, cmd_len, pl_valid, pl_data, data_in_req_from_core,
        output cmd_ready, pl_ready, core_packet, core_in_val, pkt_sent
    );
endinterface

// File: rtl/core_ni_inject.sv
// NI injection: turns a (dest, len) command plus buffered payload words into a
// header flit followed by len body flits toward the router core.
module core_ni_inject #(
    parameter logic [7:0] SRC_ADDR   = 8'h11,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic            clk0,
    input  logic            reset,
    core_ni_inject_if.slave ni
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q;
    logic [7:0]    dest_q;
    logic [3:0]    len_q, remaining_q;
    logic [11:0]   seq_q;
    logic          live_q, pkt_sent_q;

    logic fifo_full, fifo_empty, push, pop, hdr_xfer, cmd_acc;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // live_q keeps both ready outputs low until the first edge after reset release.
    assign ni.pl_ready  = live_q && !fifo_full;
    assign ni.cmd_ready = live_q && (state_q == IDLE);
    assign ni.pkt_sent  = pkt_sent_q;

    assign push     = ni.pl_valid && ni.pl_ready;
    assign pop      = (state_q == BODY) && !fifo_empty && ni.data_in_req_from_core;
    assign hdr_xfer = (state_q == HDR) && ni.data_in_req_from_core;
    assign cmd_acc  = ni.cmd_valid && ni.cmd_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk0) begin
        if (push)
            mem_q[wr_ptr_q] <= ni.pl_data;
    end

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            seq_q       <= '0;
            live_q      <= 1'b0;
            pkt_sent_q  <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            pkt_sent_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_acc) begin
                        dest_q      <= ni.cmd_dest;
                        len_q       <= ni.cmd_len;
                        remaining_q <= ni.cmd_len;
                        state_q     <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_xfer) begin
                        seq_q <= seq_q + 12'd1;
                        if (len_q != 4'd0) begin
                            state_q <= BODY;
                        end else begin
                            state_q    <= IDLE;
                            pkt_sent_q <= 1'b1;
                        end
                    end
                end
                BODY: begin
                    if (pop) begin
                        remaining_q <= remaining_q - 4'd1;
                        if (remaining_q == 4'd1) begin
                            state_q    <= IDLE;
                            pkt_sent_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Body flits come straight off the FIFO head; it only moves on a pop, so a stalled flit holds.
    always_comb begin
        ni.core_in_val = 1'b0;
        ni.core_packet = 32'h0;
        case (state_q)
            HDR: begin
                ni.core_in_val = 1'b1;
                ni.core_packet = {dest_q, SRC_ADDR, len_q, seq_q};
            end
            BODY: begin
                ni.core_in_val = !fifo_empty;
                ni.core_packet = mem_q[rd_ptr_q];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_core_ni_inject.sv
// Bench for core_ni_inject: queue-based packet model checked every cycle plus
// directed scenarios with literal flit expectations.
module tb_core_ni_inject;
    localparam int DEPTH = 8;

    logic clk0  = 1'b0;
    logic reset = 1'b1;
    core_ni_inject_if bus();

    core_ni_inject #(.SRC_ADDR(8'h11), .FIFO_DEPTH(DEPTH)) dut (
        .clk0 (clk0),
        .reset(reset),
        .ni   (bus.slave)
    );

    always #5 clk0 = ~clk0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk0) cyc++;

    // Model: payload words waiting, and the packet currently owed to the router.
    logic [31:0] pl_m[$];
    logic [31:0] got[$];
    int          got_cyc[$];
    int          sent_cnt = 0;
    bit          m_busy = 0, m_hdr = 0, m_active = 0, m_sent = 0;
    logic [7:0]  m_dest = '0;
    logic [3:0]  m_len = '0;
    int          m_rem = 0;
    int          m_seq = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] flit(int i);
        return (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int cyc_of(int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -100;
    endfunction

    always @(negedge clk0) begin
        logic [31:0] hdr;
        bit xv, push_ok, acc;
        if (!reset) begin
            chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
            chk("rst_core_in_val", 32'(bus.core_in_val), 32'd0);
            chk("rst_core_packet", bus.core_packet, 32'h0);
            chk("rst_pkt_sent", 32'(bus.pkt_sent), 32'd0);
            pl_m.delete();
            m_busy = 0; m_hdr = 0; m_active = 0; m_sent = 0; m_seq = 0; m_rem = 0;
        end else begin
            hdr = {m_dest, 8'h11, m_len, 12'(m_seq)};
            xv  = m_busy && (m_hdr || pl_m.size() != 0);
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_active && !m_busy));
            chk("pl_ready", 32'(bus.pl_ready), 32'(m_active && pl_m.size() < DEPTH));
            chk("pkt_sent", 32'(bus.pkt_sent), 32'(m_sent));
            chk("core_in_val", 32'(bus.core_in_val), 32'(xv));
            if (!m_busy)     chk("idle_packet", bus.core_packet, 32'h0);
            else if (m_hdr)  chk("header_flit", bus.core_packet, hdr);
            else if (xv)     chk("body_flit", bus.core_packet, pl_m[0]);

            if (bus.core_in_val && bus.data_in_req_from_core) begin
                got.push_back(bus.core_packet);
                got_cyc.push_back(cyc);
                $display("flit %h transferred at cycle %0d", bus.core_packet, cyc);
            end
            if (bus.pkt_sent) sent_cnt++;

            push_ok = bus.pl_valid && m_active && pl_m.size() < DEPTH;
            acc     = bus.cmd_valid && m_active && !m_busy;
            m_sent  = 0;
            if (xv && bus.data_in_req_from_core) begin
                if (m_hdr) begin
                    m_seq = (m_seq + 1) % 4096;
                    m_hdr = 0;
                    if (m_len == 4'd0) begin m_busy = 0; m_sent = 1; end
                end else begin
                    void'(pl_m.pop_front());
                    m_rem--;
                    if (m_rem == 0) begin m_busy = 0; m_sent = 1; end
                end
            end
            if (acc) begin
                m_busy = 1; m_hdr = 1;
                m_dest = bus.cmd_dest; m_len = bus.cmd_len; m_rem = int'(bus.cmd_len);
            end
            if (push_ok) pl_m.push_back(bus.pl_data);
            m_active = 1;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk0); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("async_core_in_val", 32'(bus.core_in_val), 32'd0);
        chk("async_core_packet", bus.core_packet, 32'h0);
        chk("async_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("async_pl_ready", 32'(bus.pl_ready), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_pl_ready", 32'(bus.pl_ready), 32'd1);
        got.delete(); got_cyc.delete(); sent_cnt = 0;
    endtask

    task automatic send_cmd(logic [7:0] d, logic [3:0] l);
        int n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_dest = d; bus.cmd_len = l;
        while (!bus.cmd_ready && n < 100) begin tick(); n++; end
        chk("cmd_accept_wait_expired", 32'(n >= 100), 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_word(logic [31:0] w);
        int n = 0;
        bus.pl_valid = 1'b1; bus.pl_data = w;
        while (!bus.pl_ready && n < 100) begin tick(); n++; end
        chk("push_wait_expired", 32'(n >= 100), 32'd0);
        tick();
        bus.pl_valid = 1'b0;
    endtask

    task automatic wait_flits(int k);
        int n = 0;
        while (got.size() < k && n < 200) begin tick(); n++; end
        chk("flit_wait_expired", 32'(n >= 200), 32'd0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_dest = '0; bus.cmd_len = '0;
        bus.pl_valid = 1'b0; bus.pl_data = '0; bus.data_in_req_from_core = 1'b1;
        #2;
        do_reset();

        // Payload ahead of its command, router always ready.
        push_word(32'hA); push_word(32'hB);
        send_cmd(8'h23, 4'd2);
        wait_flits(3);
        chk("t1_hdr", flit(0), 32'h2311_2000);
        chk("t1_w0", flit(1), 32'hA);
        chk("t1_w1", flit(2), 32'hB);
        chk("t1_consecutive", 32'(cyc_of(2) - cyc_of(0)), 32'd2);
        chk("t1_sent", 32'(sent_cnt), 32'd1);

        // Header-only packets; sequence number advances.
        do_reset();
        send_cmd(8'h05, 4'd0);
        wait_flits(1);
        chk("t2_hdr0", flit(0), 32'h0511_0000);
        chk("t2_sent", 32'(sent_cnt), 32'd1);
        send_cmd(8'h05, 4'd0);
        wait_flits(2);
        chk("t2_hdr1", flit(1), 32'h0511_0001);

        // Router stall of 5 cycles mid-body.
        do_reset();
        push_word(32'h100); push_word(32'h101); push_word(32'h102);
        send_cmd(8'h30, 4'd3);
        tick(2);
        bus.data_in_req_from_core = 1'b0;
        tick(3);
        chk("t3_stall_val", 32'(bus.core_in_val), 32'd1);
        chk("t3_stall_pkt", bus.core_packet, 32'h101);
        tick(2);
        bus.data_in_req_from_core = 1'b1;
        wait_flits(4);
        chk("t3_hdr", flit(0), 32'h3011_3000);
        chk("t3_order", {flit(1)[11:0], flit(2)[11:0], flit(3)[7:0]}, 32'h1001_0102);
        chk("t3_count", 32'(got.size()), 32'd4);

        // FIFO fill, then simultaneous push and pop at depth-1.
        do_reset();
        bus.data_in_req_from_core = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_word(32'h200 + 32'(i));
        chk("t4_full", 32'(bus.pl_ready), 32'd0);
        send_cmd(8'h40, 4'd8);
        bus.data_in_req_from_core = 1'b1;
        tick(2);
        bus.pl_valid = 1'b1; bus.pl_data = 32'h2FF;
        tick(1);
        bus.pl_valid = 1'b0; bus.data_in_req_from_core = 1'b0;
        chk("t4_occ_unchanged", 32'(bus.pl_ready), 32'd1);
        push_word(32'h300);
        chk("t4_full_again", 32'(bus.pl_ready), 32'd0);
        bus.data_in_req_from_core = 1'b1;
        wait_flits(9);
        chk("t4_body1", flit(2), 32'h201);
        chk("t4_body7", flit(8), 32'h207);

        // Slow payload: one word every four cycles.
        do_reset();
        send_cmd(8'h51, 4'd3);
        for (int i = 0; i < 3; i++) begin
            tick(3);
            push_word(32'h500 + 32'(i));
        end
        wait_flits(4);
        chk("t5_hdr", flit(0), 32'h5111_3000);
        chk("t5_w2", flit(3), 32'h502);
        chk("t5_count", 32'(got.size()), 32'd4);
        chk("t5_sent", 32'(sent_cnt), 32'd1);

        // Reset mid-body drops the packet and its queued payload.
        do_reset();
        push_word(32'h600);
        send_cmd(8'h60, 4'd3);
        tick(2);
        bus.data_in_req_from_core = 1'b0;
        push_word(32'h601);
        do_reset();
        bus.data_in_req_from_core = 1'b1;
        send_cmd(8'h42, 4'd1);
        push_word(32'h77);
        wait_flits(2);
        chk("t6_hdr", flit(0), 32'h4211_1000);
        chk("t6_body", flit(1), 32'h77);
        chk("t6_count", 32'(got.size()), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
